ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  - N-way round-robin arbiter and sequencer for the single shared RAM port.
//  - Requesters are the icache/dcache ports of every core (dual-core: i0,d0,i1,d1).
//  - Selects one owner, holds the RAM request stable until the RAM returns ACCESS,
//    then releases the owner and advances priority. Coherence is handled elsewhere.
//  - Sits between the per-core cache controllers and the RAM in the memory system.
// PARAMETERS
//  N_REQ      4    number of requesters; index = core*2 + (0:icache, 1:dcache)
//  ADDR_W     32   address width (word_t)
//  DATA_W     32   data width (word_t)
// PORTS
//  CLK        in   1               system clock, rising edge
//  nRST       in   1               asynchronous active-low reset
//  req_ren    in   N_REQ           per-requester read request
//  req_wen    in   N_REQ           per-requester write request
//  req_addr   in   N_REQ x ADDR_W  per-requester address
//  req_store  in   N_REQ x DATA_W  per-requester write data
//  req_wait   out  N_REQ           1 = stall; 0 for exactly one cycle on completion
//  req_load   out  DATA_W          read data, ramload broadcast, valid when req_wait[i]=0
//  ramstate   in   2               ramstate_t: FREE, BUSY, ACCESS, ERROR
//  ramload    in   DATA_W          RAM read data
//  ramREN     out  1               RAM read enable
//  ramWEN     out  1               RAM write enable
//  ramaddr    out  ADDR_W          RAM address
//  ramstore   out  DATA_W          RAM write data
//  grant_vld  out  1               an owner is currently held (state OWNED)
//  grant_id   out  $clog2(N_REQ)   index of current owner (0 when grant_vld=0)
// BEHAVIOUR
//  - Reset (async): state=IDLE, rr_ptr=0, owner=0; ramREN=ramWEN=0, ramaddr=ramstore=0,
//    grant_vld=0, grant_id=0, req_wait='1 (all 1).
//  - Requester i is active when req_ren[i] | req_wen[i].
//  - IDLE: RAM enables 0, all req_wait=1. If any requester is active, pick the first
//    active index searching rr_ptr, rr_ptr+1, ... (mod N_REQ). Register it as owner
//    and go to OWNED. Arbitration latency: exactly 1 cycle (IDLE) before RAM is driven.
//  - OWNED: ramaddr=req_addr[owner] and ramstore=req_store[owner], both combinational.
//    ramWEN=req_wen[owner]; ramREN=req_ren[owner] & ~req_wen[owner] (write wins if both).
//    Non-owners keep req_wait=1.
//    ramstate==ACCESS: req_wait[owner]=0 in that same cycle (combinational). Next state
//      is IDLE; rr_ptr <= owner+1 (mod N_REQ).
//    ramstate BUSY/FREE: hold; req_wait[owner]=1.
//    ramstate ERROR: hold and keep reissuing; req_wait[owner]=1; no rr_ptr change.
//    Owner drops its request (ren=wen=0) before ACCESS: abort. Go to IDLE next cycle,
//      enables 0 in the drop cycle, rr_ptr unchanged.
//  - Back-to-back: after every completion the FSM passes through one IDLE cycle, so a
//    transfer costs (RAM latency + 1) cycles.
//  - Fairness: a continuously active requester is granted within N_REQ-1 completions.
//  - Owner address/data changing mid-grant is forwarded as-is. Keeping them stable is
//    the requester's obligation.
//  - Reset asserted mid-transaction: immediate return to reset values; no completion.
// TESTING
//  1 Reset: nRST=0 with all req_ren=1 -> ramREN=0, req_wait=4'b1111, grant_vld=0.
//  2 Single read: req_ren[1]=1, addr=0x100, RAM ACCESS after 3 cycles ->
//    ramREN=1/ramaddr=0x100 from cycle 2; req_wait[1]=0 for 1 cycle; rr_ptr=2.
//  3 Contention: req_ren=4'b1111 held, ACCESS latency 2 -> grant order 0,1,2,3,0.
//    Each grant takes 3 cycles; no requester is granted twice before all others.
//  4 Read+write same port: req_ren[3]=req_wen[3]=1, store=0xDEADBEEF ->
//    ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
//  5 Abort: owner 2 drops its request while ramstate=BUSY -> IDLE next cycle;
//    rr_ptr stays 2; req_wait[2] never 0.
//  6 ERROR then ACCESS: ramstate=ERROR 2 cycles, then ACCESS -> request held
//    throughout; single completion pulse on the ACCESS cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for the single shared RAM port.
// Picks one cache requester, holds its RAM request until the RAM answers
// ACCESS, pulses that requester's wait low for one cycle, then rotates priority.
module ram_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_REQ-1:0]                    req_ren_i,
    input  logic [N_REQ-1:0]                    req_wen_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]        req_addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]        req_store_i,
    output logic [N_REQ-1:0]                    req_wait_o,
    output logic [DATA_W-1:0]                   req_load_o,
    input  logic [1:0]                          ramstate_i,
    input  logic [DATA_W-1:0]                   ramload_i,
    output logic                                ramREN_o,
    output logic                                ramWEN_o,
    output logic [ADDR_W-1:0]                   ramaddr_o,
    output logic [DATA_W-1:0]                   ramstore_o,
    output logic                                grant_vld_o,
    output logic [$clog2(N_REQ)-1:0]            grant_id_o
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic [N_REQ-1:0]   active;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [IDX_W-1:0]   ownerNext;
    logic               ownerActive;
    logic               ramAccess;

    assign active      = req_ren_i | req_wen_i;
    assign ownerActive = active[owner_q];
    assign ramAccess   = (ramstate_t'(ramstate_i) == RAM_ACCESS);
    assign ownerNext   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Read data is broadcast; only the requester whose wait drops consumes it.
    assign req_load_o = ramload_i;

    // Search for the first active requester starting at the round-robin pointer.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(rrPtr_q) + k) % N_REQ);
            if (!found && active[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic and RAM/requester outputs; the owner's request is forwarded live.
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        owner_d     = owner_q;
        req_wait_o  = '1;
        ramREN_o    = 1'b0;
        ramWEN_o    = 1'b0;
        ramaddr_o   = '0;
        ramstore_o  = '0;
        grant_vld_o = 1'b0;
        grant_id_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                grant_vld_o = 1'b1;
                grant_id_o  = owner_q;
                ramaddr_o   = req_addr_i[owner_q];
                ramstore_o  = req_store_i[owner_q];
                if (!ownerActive) begin
                    state_d = ST_IDLE;
                end else begin
                    ramWEN_o = req_wen_i[owner_q];
                    ramREN_o = req_ren_i[owner_q] & ~req_wen_i[owner_q];
                    if (ramAccess) begin
                        req_wait_o[owner_q] = 1'b0;
                        state_d             = ST_IDLE;
                        rrPtr_d             = ownerNext;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, priority pointer and owner registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rrPtr_q <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected completions,
// a monitor pops and checks them whenever a requester's wait drops.
module tb_ram_arbiter;

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [3:0]        reqRen = '0;
    logic [3:0]        reqWen = '0;
    logic [3:0][31:0]  reqAddr = '0;
    logic [3:0][31:0]  reqStore = '0;
    logic [3:0]        reqWait;
    logic [31:0]       reqLoad;
    logic [1:0]        ramstate = RAM_FREE;
    logic [31:0]       ramload = '0;
    logic              ramRen;
    logic              ramWen;
    logic [31:0]       ramAddr;
    logic [31:0]       ramStore;
    logic              grantVld;
    logic [1:0]        grantId;

    typedef struct {
        int          id;
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monEntry;
    logic [3:0]  expWait;
    int          checks = 0;
    int          failures = 0;
    int          doneCount = 0;
    int          cycleCount = 0;
    int          lastCycle = 0;
    bit          haveLast = 1'b0;
    int          expectedInterval = 0;
    int          ramLatency = 1;
    int          ramErrCycles = 0;
    int          ramIdx = 0;
    logic [3:0]  doneMask = '0;

    ram_arbiter #(.N_REQ(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_ren_i   (reqRen),
        .req_wen_i   (reqWen),
        .req_addr_i  (reqAddr),
        .req_store_i (reqStore),
        .req_wait_o  (reqWait),
        .req_load_o  (reqLoad),
        .ramstate_i  (ramstate),
        .ramload_i   (ramload),
        .ramREN_o    (ramRen),
        .ramWEN_o    (ramWen),
        .ramaddr_o   (ramAddr),
        .ramstore_o  (ramStore),
        .grant_vld_o (grantVld),
        .grant_id_o  (grantId)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input bit ren, input bit wen,
                                 input logic [31:0] addr, input logic [31:0] store);
        reqRen[id]   = ren;
        reqWen[id]   = wen;
        reqAddr[id]  = addr;
        reqStore[id] = store;
    endtask

    task automatic pushExp(input int id, input bit isWrite, input logic [31:0] addr,
                           input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.id = id; e.isWrite = isWrite; e.addr = addr; e.store = store; e.load = load;
        expQ.push_back(e);
    endtask

    // Advance cycles until the monitor has seen 'target' completions, optionally
    // dropping each requester the cycle after it completes.
    task automatic runUntil(input int target, input bit autoRelease);
        int budget;
        budget = 0;
        while (doneCount < target && budget < 300) begin
            @(posedge clk);
            #1;
            if (autoRelease) begin
                reqRen = reqRen & ~doneMask;
                reqWen = reqWen & ~doneMask;
            end
            budget++;
        end
        if (doneCount < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL completion_timeout actual=%0d required=%0d", doneCount, target);
        end
    endtask

    // Cycle counter used for grant-interval checks.
    initial forever begin
        @(posedge clk);
        cycleCount++;
    end

    // RAM model: BUSY for latency-1 cycles, then ERROR cycles, then one ACCESS.
    initial forever begin
        @(posedge clk);
        #2;
        if (ramRen || ramWen) begin
            if (ramIdx == ramLatency - 1 + ramErrCycles)      ramstate = RAM_ACCESS;
            else if (ramIdx >= ramLatency - 1)                ramstate = RAM_ERROR;
            else                                              ramstate = RAM_BUSY;
            ramIdx++;
        end else begin
            ramIdx   = 0;
            ramstate = RAM_FREE;
        end
    end

    // Monitor: every completion pulse pops the next expected transfer.
    initial forever begin
        @(negedge clk);
        if (!rstN) begin
            doneMask = '0;
        end else begin
            doneMask = ~reqWait;
            if (expectedInterval == 0) haveLast = 1'b0;
            if (reqWait != 4'hF) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_completion wait=%b required=1111", reqWait);
                end else begin
                    monEntry = expQ.pop_front();
                    expWait = 4'hF;
                    expWait[monEntry.id] = 1'b0;
                    checkOutput("done_wait", 32'(reqWait), 32'(expWait));
                    checkOutput("done_grant_vld", 32'(grantVld), 32'd1);
                    checkOutput("done_grant_id", 32'(grantId), 32'(monEntry.id));
                    checkOutput("done_ramaddr", ramAddr, monEntry.addr);
                    checkOutput("done_ramWEN", 32'(ramWen), 32'(monEntry.isWrite));
                    checkOutput("done_ramREN", 32'(ramRen), 32'(!monEntry.isWrite));
                    if (monEntry.isWrite) checkOutput("done_ramstore", ramStore, monEntry.store);
                    else                  checkOutput("done_req_load", reqLoad, monEntry.load);
                    if (expectedInterval != 0 && haveLast)
                        checkOutput("grant_interval", 32'(cycleCount - lastCycle), 32'(expectedInterval));
                    haveLast  = (expectedInterval != 0);
                    lastCycle = cycleCount;
                    doneCount++;
                end
            end
        end
    end

    // Global time limit so the run always ends with a summary line.
    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog_expired actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed test sequence.
    initial begin
        for (int i = 0; i < 4; i++) reqAddr[i] = 32'hAAAA_0000 + 32'(i);

        // Reset with every requester active.
        reqRen = 4'hF;
        repeat (2) @(negedge clk);
        checkOutput("rst_ramREN", 32'(ramRen), 32'd0);
        checkOutput("rst_ramWEN", 32'(ramWen), 32'd0);
        checkOutput("rst_req_wait", 32'(reqWait), 32'hF);
        checkOutput("rst_grant_vld", 32'(grantVld), 32'd0);
        checkOutput("rst_grant_id", 32'(grantId), 32'd0);
        checkOutput("rst_ramaddr", ramAddr, 32'd0);
        reqRen = '0;
        @(posedge clk); #1 rstN = 1'b1;

        // Single read from requester 1, ACCESS on the third RAM cycle.
        @(posedge clk); #1;
        ramLatency = 3; ramErrCycles = 0; ramload = 32'h1111_0100;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        pushExp(1, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_0100);
        @(negedge clk);
        checkOutput("arb_latency_ramREN", 32'(ramRen), 32'd0);
        checkOutput("arb_latency_grant_vld", 32'(grantVld), 32'd0);
        @(negedge clk);
        checkOutput("read_ramREN", 32'(ramRen), 32'd1);
        checkOutput("read_ramaddr", ramAddr, 32'h0000_0100);
        checkOutput("read_grant_id", 32'(grantId), 32'd1);
        checkOutput("read_wait_held", 32'(reqWait), 32'hF);
        runUntil(doneCount + 1, 1'b1);

        // Requesters 3 (read+write) and 1 together: pointer at 2 means 3 wins first.
        @(posedge clk); #1;
        ramLatency = 2; ramload = 32'h2222_0000;
        applyStimulus(3, 1'b1, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
        pushExp(3, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0);
        pushExp(1, 1'b0, 32'h0000_0104, 32'h0, 32'h2222_0000);
        runUntil(doneCount + 2, 1'b1);

        // Reset in the middle of a transfer: no completion may follow.
        @(posedge clk); #1;
        ramLatency = 6;
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0050, 32'h0);
        for (int k = 0; k < 20 && !grantVld; k++) @(negedge clk);
        checkOutput("midrst_granted", 32'(grantVld), 32'd1);
        @(posedge clk); #1 rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst_grant_vld", 32'(grantVld), 32'd0);
        checkOutput("midrst_ramREN", 32'(ramRen), 32'd0);
        checkOutput("midrst_req_wait", 32'(reqWait), 32'hF);
        reqRen = '0;
        @(posedge clk); #1 rstN = 1'b1;

        // Contention: all four read continuously; order 0,1,2,3,0, three cycles apart.
        @(posedge clk); #1;
        ramLatency = 2; ramload = 32'h3333_0000; expectedInterval = 3;
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i), 32'h0);
        for (int i = 0; i < 5; i++) pushExp(i % 4, 1'b0, 32'h0000_1000 + 32'(4 * (i % 4)), 32'h0, 32'h3333_0000);
        runUntil(doneCount + 5, 1'b0);
        reqRen = '0;
        expectedInterval = 0;

        // Requester 1 once more so the pointer lands on 2.
        @(posedge clk); #1;
        ramLatency = 1; ramload = 32'h4444_0000;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        pushExp(1, 1'b0, 32'h0000_0200, 32'h0, 32'h4444_0000);
        runUntil(doneCount + 1, 1'b1);

        // Abort: owner 2 drops its request while the RAM is BUSY.
        @(posedge clk); #1;
        ramLatency = 6;
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_02A0, 32'h0);
        for (int k = 0; k < 20 && !(grantVld && grantId == 2'd2); k++) @(negedge clk);
        checkOutput("abort_grant_id", 32'(grantId), 32'd2);
        @(posedge clk); #1;
        reqRen[2] = 1'b0;
        @(negedge clk);
        checkOutput("abort_drop_ramREN", 32'(ramRen), 32'd0);
        checkOutput("abort_drop_wait", 32'(reqWait), 32'hF);
        @(negedge clk);
        checkOutput("abort_idle_grant_vld", 32'(grantVld), 32'd0);

        // Pointer must still be 2 after the abort: order 2,3,1.
        @(posedge clk); #1;
        ramLatency = 1; ramload = 32'h5555_0000;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0510, 32'h0);
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_0520, 32'h0);
        applyStimulus(3, 1'b1, 1'b0, 32'h0000_0530, 32'h0);
        pushExp(2, 1'b0, 32'h0000_0520, 32'h0, 32'h5555_0000);
        pushExp(3, 1'b0, 32'h0000_0530, 32'h0, 32'h5555_0000);
        pushExp(1, 1'b0, 32'h0000_0510, 32'h0, 32'h5555_0000);
        runUntil(doneCount + 3, 1'b1);

        // ERROR for two cycles, then ACCESS: request held and a single completion.
        @(posedge clk); #1;
        ramLatency = 1; ramErrCycles = 2;
        applyStimulus(0, 1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D);
        pushExp(0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0);
        for (int k = 0; k < 20 && ramstate != RAM_ERROR; k++) @(negedge clk);
        checkOutput("err1_ramWEN", 32'(ramWen), 32'd1);
        checkOutput("err1_wait", 32'(reqWait), 32'hF);
        @(negedge clk);
        checkOutput("err2_ramWEN", 32'(ramWen), 32'd1);
        checkOutput("err2_wait", 32'(reqWait), 32'hF);
        checkOutput("err2_ramstore", ramStore, 32'hCAFE_F00D);
        runUntil(doneCount + 1, 1'b1);
        ramErrCycles = 0;

        repeat (4) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("final_idle_wait", 32'(reqWait), 32'hF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
